// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller: 4 lines x 4 words
// of 32 bits over a 10-bit byte address, with a line-wide memory handshake.
module cache_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 read_write,
    input  logic [9:0]           address,
    input  logic [31:0]          write_data,
    output logic                 hit_miss,
    output logic [31:0]          read_data,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [9:0]           mem_address,
    output logic [127:0]         mem_write_data,
    input  logic [127:0]         mem_read_data,
    input  logic                 mem_ready,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {
        COMPARE    = 2'd0,
        WRITE_BACK = 2'd1,
        ALLOCATE   = 2'd2
    } state_t;

    state_t       state;
    logic [3:0]   tag_mem  [4];
    logic [127:0] data_mem [4];
    logic [3:0]   valid;
    logic [3:0]   dirty;

    logic [3:0] req_tag;
    logic [1:0] index;
    logic [1:0] word;
    logic [6:0] word_lsb;
    logic       hit;
    logic       unused_byte_offset;

    assign req_tag            = address[9:6];
    assign index              = address[5:4];
    assign word               = address[3:2];
    assign word_lsb           = {word, 5'b0};
    assign unused_byte_offset = ^address[1:0];

    assign hit       = (state == COMPARE) && valid[index] && (tag_mem[index] == req_tag);
    assign hit_miss  = hit && !reset;
    assign read_data = (hit_miss && !read_write) ? data_mem[index][word_lsb +: 32] : 32'd0;

    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        case (state)
            WRITE_BACK: begin
                mem_address    = {tag_mem[index], index, 4'b0000};
                mem_write_data = data_mem[index];
            end
            ALLOCATE: mem_address = {req_tag, index, 4'b0000};
            default: ;
        endcase
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide
    // whether their contents mean anything, so only those are cleared.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (hit && read_write) begin
                data_mem[index][word_lsb +: 32] <= write_data;
            end else if (state == ALLOCATE && mem_ready) begin
                data_mem[index] <= mem_read_data;
                tag_mem[index]  <= req_tag;
            end
        end
    end

    // mem_read/mem_write are set on the same edges that enter their states,
    // so they mirror the state decode while still coming straight from flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= COMPARE;
            valid      <= '0;
            dirty      <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                COMPARE: begin
                    if (hit) begin
                        if (read_write) dirty[index] <= 1'b1;
                        if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
                        if (valid[index] && dirty[index]) begin
                            state     <= WRITE_BACK;
                            mem_write <= 1'b1;
                        end else begin
                            state    <= ALLOCATE;
                            mem_read <= 1'b1;
                        end
                    end
                end
                WRITE_BACK: begin
                    if (mem_ready) begin
                        dirty[index] <= 1'b0;
                        state        <= ALLOCATE;
                        mem_write    <= 1'b0;
                        mem_read     <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        valid[index] <= 1'b1;
                        dirty[index] <= 1'b0;
                        state        <= COMPARE;
                        mem_read     <= 1'b0;
                    end
                end
                default: begin
                    state     <= COMPARE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: requests push expected completions,
// a negedge monitor pops them whenever hit_miss is presented.
module tb_cache_controller;

    localparam int CW = 4;

    logic          clock;
    logic          reset;
    logic          read_write;
    logic [9:0]    address;
    logic [31:0]   write_data;
    logic          hit_miss;
    logic [31:0]   read_data;
    logic          mem_read;
    logic          mem_write;
    logic [9:0]    mem_address;
    logic [127:0]  mem_write_data;
    logic [127:0]  mem_read_data;
    logic          mem_ready;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    cache_controller #(.CNT_WIDTH(CW)) dut (
        .clock          (clock),
        .reset          (reset),
        .read_write     (read_write),
        .address        (address),
        .write_data     (write_data),
        .hit_miss       (hit_miss),
        .read_data      (read_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    typedef struct {
        logic        rw;
        logic [9:0]  addr;
        logic [31:0] rdata;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [127:0] mem_model [64];
    int           mem_latency = 1;
    bit           mem_stall   = 0;
    bit           spurious    = 0;
    int           wait_cnt    = 0;
    int           wb_cycles   = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Line-granular memory: answers after mem_latency extra cycles.
    always @(negedge clock) begin
        mem_ready = 1'b0;
        if (mem_write) wb_cycles++;
        if ((mem_read || mem_write) && !mem_stall) begin
            if (wait_cnt >= mem_latency) begin
                mem_ready = 1'b1;
                wait_cnt  = 0;
                if (mem_read) mem_read_data = mem_model[mem_address[9:4]];
                else          mem_model[mem_address[9:4]] = mem_write_data;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (spurious && !mem_read && !mem_write) mem_ready = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (hit_miss) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_completion: addr %h completed with no request pending", address);
            end else begin
                e = sb.pop_front();
                if (address !== e.addr || read_data !== e.rdata) begin
                    errors++;
                    $display("FAIL completion_%h: got addr %h read_data %h, expected addr %h read_data %h",
                             e.addr, address, read_data, e.addr, e.rdata);
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic rw, input logic [9:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd);
        read_write = rw;
        address    = addr;
        write_data = wd;
        sb.push_back('{rw, addr, exp_rd});
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Called at a negedge; waits for completion, then moves past the posedge.
    task automatic wait_done(input string name);
        int n = 0;
        while (!hit_miss && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!hit_miss) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no hit_miss within 50 cycles", name);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int wb_before;
        for (int l = 0; l < 64; l++)
            for (int w = 0; w < 4; w++)
                mem_model[l][w*32 +: 32] = 32'hA000_0000 | 32'(l * 16 + w * 4);
        mem_model[6'h1A][95:64] = 32'h11;
        mem_ready     = 1'b0;
        mem_read_data = '0;
        reset         = 1'b1;
        read_write    = 1'b0;
        address       = 10'h1A9;
        write_data    = '0;

        repeat (2) @(posedge clock);
        step();
        check("rst_hit_miss", hit_miss, 0);
        check("rst_read_data", read_data, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_write_data", mem_write_data, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Clean read miss, refill, then hit.
        issue(1'b0, 10'h1A9, 32'h0, 32'h11);
        step();
        check("t1_compare_hit_miss", hit_miss, 0);
        check("t1_compare_mem_read", mem_read, 0);
        step();
        check("t1_alloc_mem_read", mem_read, 1);
        check("t1_alloc_mem_write", mem_write, 0);
        check("t1_alloc_mem_address", mem_address, 10'h1A0);
        check("t1_alloc_hit_miss", hit_miss, 0);
        wait_done("t1");
        check("t1_hit_count", hit_count, 1);
        check("t1_miss_count", miss_count, 1);

        // Write miss to an invalid line: refill then write hit, no write-back.
        wb_before = wb_cycles;
        issue(1'b1, 10'h195, 32'hFAC, 32'h0);
        step();
        check("t2_compare_hit_miss", hit_miss, 0);
        step();
        check("t2_alloc_mem_read", mem_read, 1);
        check("t2_alloc_mem_address", mem_address, 10'h190);
        wait_done("t2_write");
        check("t2_no_write_back", wb_cycles - wb_before, 0);
        issue(1'b0, 10'h195, 32'h0, 32'hFAC);
        step();
        check("t2_read_back_hit", hit_miss, 1);
        wait_done("t2_read");

        // Dirty conflict: write-back then refill, 1-cycle transactions.
        mem_latency = 0;
        issue(1'b0, 10'h154, 32'h0, 32'hA000_0154);
        step();
        check("t3_compare_hit_miss", hit_miss, 0);
        step();
        check("t3_wb_mem_write", mem_write, 1);
        check("t3_wb_mem_read", mem_read, 0);
        check("t3_wb_mem_address", mem_address, 10'h190);
        check("t3_wb_data", mem_write_data,
              {32'hA000_019C, 32'hA000_0198, 32'h0000_0FAC, 32'hA000_0190});
        step();
        check("t3_alloc_mem_read", mem_read, 1);
        check("t3_alloc_mem_write", mem_write, 0);
        check("t3_alloc_mem_address", mem_address, 10'h150);
        check("t3_alloc_hit_miss", hit_miss, 0);
        wait_done("t3");

        // Clean miss on the evicted line fetches the written-back word.
        issue(1'b0, 10'h195, 32'h0, 32'hFAC);
        step();
        check("t4_compare_hit_miss", hit_miss, 0);
        step();
        check("t4_alloc_mem_read", mem_read, 1);
        check("t4_alloc_mem_write", mem_write, 0);
        check("t4_alloc_mem_address", mem_address, 10'h190);
        wait_done("t4");
        check("t4_hit_count", hit_count, 5);
        check("t4_miss_count", miss_count, 4);

        // Reset while a refill is stalled abandons it and invalidates all lines.
        mem_latency = 1;
        mem_stall   = 1;
        issue(1'b0, 10'h2A4, 32'h0, 32'hA000_02A4);
        step();
        check("t5_compare_hit_miss", hit_miss, 0);
        step();
        check("t5_alloc_mem_read", mem_read, 1);
        check("t5_alloc_mem_address", mem_address, 10'h2A0);
        step();
        reset = 1'b1;
        @(posedge clock);
        #1;
        step();
        check("t5_rst_mem_read", mem_read, 0);
        check("t5_rst_mem_write", mem_write, 0);
        check("t5_rst_mem_address", mem_address, 0);
        check("t5_rst_hit_miss", hit_miss, 0);
        check("t5_rst_hit_count", hit_count, 0);
        check("t5_rst_miss_count", miss_count, 0);
        reset     = 1'b0;
        mem_stall = 0;
        step();
        check("t5_remiss_mem_read", mem_read, 1);
        check("t5_remiss_mem_address", mem_address, 10'h2A0);
        wait_done("t5_remiss");
        issue(1'b0, 10'h195, 32'h0, 32'hFAC);
        step();
        check("t5_line1_invalid", hit_miss, 0);
        wait_done("t5_line1");
        check("t5_hit_count", hit_count, 2);
        check("t5_miss_count", miss_count, 2);

        // Back-to-back hits with stray mem_ready pulses; hit_count saturates.
        spurious = 1;
        for (int i = 0; i < 20; i++) begin
            issue(1'b0, 10'h195, 32'h0, 32'hFAC);
            step();
            check("t6_hit", hit_miss, 1);
            check("t6_mem_read_idle", mem_read, 0);
            wait_done("t6");
        end
        spurious = 0;
        check("t6_hit_count_saturated", hit_count, 15);
        check("t6_miss_count", miss_count, 2);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
